// File: rtl/cpu_block_xfer_seq.sv
// Block-transfer sequencer for LDM/STM and Thumb PUSH/POP/LDMIA/STMIA.
// It issues one word beat per listed register, lowest register first, then optionally pulses base writeback.
module cpu_block_xfer_seq #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_load,
    input  logic                P,
    input  logic                U,
    input  logic                S,
    input  logic                W,
    input  logic [IDX_W-1:0]    rn,
    input  logic [NUM_REGS-1:0] reg_list,
    input  logic [ADDR_W-1:0]   base,
    output logic                busy,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    output logic [IDX_W-1:0]    xfer_reg,
    output logic                xfer_first,
    output logic                xfer_last,
    output logic                force_user,
    output logic                wb_en,
    output logic [ADDR_W-1:0]   wb_value,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]   FOUR       = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0]   ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [NUM_REGS-1:0] LIST_ONE   = NUM_REGS'(1'b1);
    localparam logic [IDX_W:0]      CNT_ONE    = (IDX_W+1)'(1'b1);

    function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] m);
        popcount = {(IDX_W+1){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            popcount = popcount + {{IDX_W{1'b0}}, m[i]};
        end
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] m);
        lowest_idx = {IDX_W{1'b0}};
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    state_t                state_r, state_s;
    logic [NUM_REGS-1:0]   rem_r, rem_s;
    logic                  wb_take_r, wb_take_s;
    logic                  busy_s, mem_req_s, xfer_first_s, xfer_last_s;
    logic                  force_user_s, wb_en_s, done_s;
    logic [ADDR_W-1:0]     mem_addr_s, wb_value_s;
    logic [IDX_W-1:0]      xfer_reg_s;

    // An empty list moves only the top register but spans the whole register file.
    logic [NUM_REGS-1:0]   eff_list_s;
    logic [IDX_W:0]        n_eff_s;
    logic [ADDR_W-1:0]     span_s, start_addr_s, wb_calc_s;
    logic [NUM_REGS-1:0]   rem_adv_s;

    assign eff_list_s = (reg_list == {NUM_REGS{1'b0}}) ? {1'b1, {(NUM_REGS-1){1'b0}}} : reg_list;
    assign n_eff_s    = (reg_list == {NUM_REGS{1'b0}}) ? (IDX_W+1)'(NUM_REGS) : popcount(reg_list);
    assign span_s     = ADDR_W'({n_eff_s, 2'b00});
    assign wb_calc_s  = U ? (base + span_s) : (base - span_s);
    assign rem_adv_s  = rem_r & (rem_r - LIST_ONE);

    // First beat address for the four addressing modes; the lowest register is always at the lowest address.
    always_comb begin
        case ({P, U})
            2'b01:   start_addr_s = base;
            2'b11:   start_addr_s = base + FOUR;
            2'b00:   start_addr_s = base - span_s + FOUR;
            2'b10:   start_addr_s = base - span_s;
            default: start_addr_s = base;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        rem_s        = rem_r;
        wb_take_s    = wb_take_r;
        busy_s       = busy;
        mem_req_s    = mem_req;
        mem_addr_s   = mem_addr;
        xfer_reg_s   = xfer_reg;
        xfer_first_s = xfer_first;
        xfer_last_s  = xfer_last;
        force_user_s = force_user;
        wb_value_s   = wb_value;
        wb_en_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = XFER;
                    rem_s        = eff_list_s;
                    wb_take_s    = W & ~(is_load & reg_list[rn]);
                    busy_s       = 1'b1;
                    mem_req_s    = 1'b1;
                    mem_addr_s   = start_addr_s & ALIGN_MASK;
                    xfer_reg_s   = lowest_idx(eff_list_s);
                    xfer_first_s = 1'b1;
                    xfer_last_s  = (popcount(eff_list_s) == CNT_ONE);
                    force_user_s = S;
                    wb_value_s   = wb_calc_s;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (xfer_last) begin
                        rem_s        = {NUM_REGS{1'b0}};
                        mem_req_s    = 1'b0;
                        xfer_first_s = 1'b0;
                        xfer_last_s  = 1'b0;
                        if (wb_take_r) begin
                            state_s = WB;
                            wb_en_s = 1'b1;
                        end else begin
                            state_s      = DONE;
                            done_s       = 1'b1;
                            busy_s       = 1'b0;
                            force_user_s = 1'b0;
                        end
                    end else begin
                        rem_s        = rem_adv_s;
                        mem_addr_s   = mem_addr + FOUR;
                        xfer_reg_s   = lowest_idx(rem_adv_s);
                        xfer_first_s = 1'b0;
                        xfer_last_s  = (popcount(rem_adv_s) == CNT_ONE);
                    end
                end else begin
                    state_s = XFER;
                end
            end
            WB: begin
                state_s      = DONE;
                done_s       = 1'b1;
                busy_s       = 1'b0;
                force_user_s = 1'b0;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s   = IDLE;
                busy_s    = 1'b0;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            rem_r      <= {NUM_REGS{1'b0}};
            wb_take_r  <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            xfer_reg   <= {IDX_W{1'b0}};
            xfer_first <= 1'b0;
            xfer_last  <= 1'b0;
            force_user <= 1'b0;
            wb_en      <= 1'b0;
            wb_value   <= {ADDR_W{1'b0}};
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            wb_take_r  <= wb_take_s;
            busy       <= busy_s;
            mem_req    <= mem_req_s;
            mem_addr   <= mem_addr_s;
            xfer_reg   <= xfer_reg_s;
            xfer_first <= xfer_first_s;
            xfer_last  <= xfer_last_s;
            force_user <= force_user_s;
            wb_en      <= wb_en_s;
            wb_value   <= wb_value_s;
            done       <= done_s;
        end
    end

endmodule
